// File: rtl/nco_multi_if.sv
// rtl/nco_multi_if.sv - AXI-stream sample output bundle for nco_multi
interface nco_multi_if #(
    parameter int OUT_DW = 16,
    parameter int CH_W   = 2
);
    logic [2*OUT_DW-1:0] tdata;
    logic [CH_W-1:0]     tuser;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport master (output tdata, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/nco_multi.sv
// rtl/nco_multi.sv - time-multiplexed multi-channel sin/cos NCO, quarter-wave LUT, AXI-stream out
// Optional phase dither: define NCO_DITHER_EN.
module nco_multi #(
    parameter int PHASE_DW = 16,
    parameter int OUT_DW   = 16,
    parameter int LUT_DW   = 10,
    parameter int CHANNELS = 4,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                cfg_wr,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PHASE_DW-1:0] cfg_inc,
    input  logic [PHASE_DW-1:0] cfg_offset,
    input  logic                cfg_clear,
    nco_multi_if.master         m_axis_out
);
    localparam int ADDR_W = LUT_DW - 2;
    localparam int AW     = (ADDR_W > 0) ? ADDR_W : 1;
    localparam int LUT_N  = 1 << ADDR_W;
    localparam int AMP    = (1 << (OUT_DW - 1)) - 1;
    localparam logic signed [127:0] PI_Q60 = 128'sh3243F6A8885A308D;
    localparam logic [LUT_DW-1:0] QUARTER = LUT_DW'(1) << (LUT_DW - 2);

    // Table is built at elaboration with Q60 fixed-point Taylor series so
    // entries equal round(AMP*sin(2*pi*(k+0.5)/2^LUT_DW)) exactly.
    function automatic logic [LUT_N*OUT_DW-1:0] lut_init();
        logic signed [127:0] x, x2, term, sum, den, kk, amp_w, prod;
        logic [LUT_N*OUT_DW-1:0] flat;
        flat  = '0;
        amp_w = 128'(AMP);
        for (int k = 0; k < LUT_N; k++) begin
            kk   = 128'(2 * k + 1);
            x    = (PI_Q60 * kk) >>> LUT_DW;
            x2   = (x * x) >>> 60;
            term = x;
            sum  = x;
            for (int i = 1; i <= 16; i++) begin
                den  = 128'(2 * i * (2 * i + 1));
                term = -(((term * x2) >>> 60) / den);
                sum  = sum + term;
            end
            prod = (sum * amp_w + (128'sd1 <<< 59)) >>> 60;
            flat[k*OUT_DW +: OUT_DW] = prod[OUT_DW-1:0];
        end
        return flat;
    endfunction

    localparam logic [LUT_N*OUT_DW-1:0] LUT_FLAT = lut_init();

    logic [PHASE_DW-1:0] acc_q [CHANNELS];
    logic [PHASE_DW-1:0] inc_q [CHANNELS];
    logic [PHASE_DW-1:0] off_q [CHANNELS];
    logic [CH_W-1:0]     ptr_q;

    logic adv, issue;
    assign adv   = !m_axis_out.tvalid || m_axis_out.tready;
    assign issue = en && adv;

    logic [PHASE_DW-1:0] phase_d;
    logic [LUT_DW-1:0]   ph_top;

`ifdef NCO_DITHER_EN
    localparam int DITH_W = PHASE_DW - LUT_DW;
    localparam logic [15:0] DITH_MASK = 16'((32'h1 << DITH_W) - 1);
    logic [15:0] lfsr_q;
    assign phase_d = acc_q[ptr_q] + off_q[ptr_q] + PHASE_DW'(lfsr_q & DITH_MASK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= 16'hACE1;
        end else if (issue) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end
`else
    assign phase_d = acc_q[ptr_q] + off_q[ptr_q];
`endif

    assign ph_top = LUT_DW'(phase_d >> (PHASE_DW - LUT_DW));

    // Stage 1: truncated phase; stage 2: quadrant fold; stage 3: LUT; stage 4: sign.
    logic              s1_vld_q;
    logic [CH_W-1:0]   s1_ch_q;
    logic [LUT_DW-1:0] s1_ph_q;
    logic              s2_vld_q, s2_sn_q, s2_cn_q;
    logic [CH_W-1:0]   s2_ch_q;
    logic [AW-1:0]     s2_sa_q, s2_ca_q;
    logic              s3_vld_q, s3_sn_q, s3_cn_q;
    logic [CH_W-1:0]   s3_ch_q;
    logic [OUT_DW-1:0] s3_sm_q, s3_cm_q;

    logic [LUT_DW-1:0] cos_ph;
    logic [AW-1:0]     sin_a, cos_a;
    assign cos_ph = s1_ph_q + QUARTER;

    generate
        if (ADDR_W > 0) begin : g_addr
            assign sin_a = s1_ph_q[LUT_DW-2] ? ~s1_ph_q[AW-1:0] : s1_ph_q[AW-1:0];
            assign cos_a = cos_ph[LUT_DW-2]  ? ~cos_ph[AW-1:0]  : cos_ph[AW-1:0];
        end else begin : g_noaddr
            assign sin_a = '0;
            assign cos_a = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c] <= '0;
                inc_q[c] <= '0;
                off_q[c] <= '0;
            end
            ptr_q    <= '0;
            s1_vld_q <= 1'b0;
            s1_ch_q  <= '0;
            s1_ph_q  <= '0;
            s2_vld_q <= 1'b0;
            s2_sn_q  <= 1'b0;
            s2_cn_q  <= 1'b0;
            s2_ch_q  <= '0;
            s2_sa_q  <= '0;
            s2_ca_q  <= '0;
            s3_vld_q <= 1'b0;
            s3_sn_q  <= 1'b0;
            s3_cn_q  <= 1'b0;
            s3_ch_q  <= '0;
            s3_sm_q  <= '0;
            s3_cm_q  <= '0;
            m_axis_out.tvalid <= 1'b0;
            m_axis_out.tdata  <= '0;
            m_axis_out.tuser  <= '0;
            m_axis_out.tlast  <= 1'b0;
        end else begin
            // A clear on the channel being issued wins over its accumulator advance.
            for (int c = 0; c < CHANNELS; c++) begin
                if (cfg_wr && cfg_ch == CH_W'(c)) begin
                    inc_q[c] <= cfg_inc;
                    off_q[c] <= cfg_offset;
                end
                if (cfg_wr && cfg_clear && cfg_ch == CH_W'(c)) begin
                    acc_q[c] <= '0;
                end else if (issue && ptr_q == CH_W'(c)) begin
                    acc_q[c] <= acc_q[c] + inc_q[c];
                end
            end
            if (issue) begin
                ptr_q <= (ptr_q == CH_W'(CHANNELS - 1)) ? '0 : ptr_q + CH_W'(1);
            end
            if (adv) begin
                s1_vld_q <= en;
                s1_ch_q  <= ptr_q;
                s1_ph_q  <= ph_top;

                s2_vld_q <= s1_vld_q;
                s2_ch_q  <= s1_ch_q;
                s2_sn_q  <= s1_ph_q[LUT_DW-1];
                s2_cn_q  <= cos_ph[LUT_DW-1];
                s2_sa_q  <= sin_a;
                s2_ca_q  <= cos_a;

                s3_vld_q <= s2_vld_q;
                s3_ch_q  <= s2_ch_q;
                s3_sn_q  <= s2_sn_q;
                s3_cn_q  <= s2_cn_q;
                s3_sm_q  <= LUT_FLAT[int'(s2_sa_q)*OUT_DW +: OUT_DW];
                s3_cm_q  <= LUT_FLAT[int'(s2_ca_q)*OUT_DW +: OUT_DW];

                m_axis_out.tvalid <= s3_vld_q;
                m_axis_out.tuser  <= s3_ch_q;
                m_axis_out.tlast  <= s3_vld_q && (s3_ch_q == CH_W'(CHANNELS - 1));
                m_axis_out.tdata  <= {s3_cn_q ? (~s3_cm_q + OUT_DW'(1)) : s3_cm_q,
                                      s3_sn_q ? (~s3_sm_q + OUT_DW'(1)) : s3_sm_q};
            end
        end
    end
endmodule
